serial_merge2: RTL
==================

# serial_merge2

Two-channel serial-bit merger directly upstream of a single-bit serial sink. It arbitrates between two 1-bit valid/ready sources in bursts, drives the select of the team's `mux2` gate-level 2:1 multiplexer, and registers the selected bit into one output slot with its own valid/ready handshake. Fairness comes from a round-robin pointer; a grant is held for at most `BURST` bits.

## Interface
- `BURST`, default 4: maximum bits transferred per grant; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `d0` in 1: channel 0 data bit.
- `v0` in 1: channel 0 valid.
- `r0` out 1: channel 0 ready; a bit transfers when `v0 & r0`.
- `d1` in 1: channel 1 data bit.
- `v1` in 1: channel 1 valid.
- `r1` out 1: channel 1 ready.
- `z` out 1: registered output bit.
- `zv` out 1: output valid.
- `zr` in 1: downstream ready; the output bit is consumed when `zv & zr`.
- `ch` out 1: source channel of the bit currently in `z`.
- `busy` out 1: high in either GRANT state.
- `stall_cnt` out 8: present only with `SERIAL_MERGE_STALL_CNT_EN`.

## Operation
- FSM states: IDLE, GRANT0, GRANT1. The state is registered.
- The data path is one `mux2` instance with `d0`, `d1`, `sel = (state==GRANT1)`, and its output feeds the `z` register.
- Round-robin pointer `pri`, reset value 0, names the preferred channel.
- IDLE:
  - Only `v0` high: go to GRANT0. Only `v1` high: go to GRANT1.
  - Both high: go to GRANT`pri`. Neither high: stay in IDLE.
  - `r0 = r1 = 0` in IDLE.
- GRANTk:
  - Slot free: `free = !zv | zr`.
  - `rk = free`; the other channel's ready is 0.
  - On transfer (`vk & rk`): `z <= dk`, `ch <= k`, `zv <= 1`, burst counter increments.
  - If `free` and not transferring: `zv <= 0`.
- Leave GRANTk for IDLE when either holds:
  - the transfer that brings the counter to `BURST` completes;
  - a cycle has `vk == 0` while `rk == 1`, i.e. the source went idle.
- On leaving GRANTk: counter clears to 0 and `pri <= ~k`.
- The counter is 4 bits and never exceeds `BURST`; it wraps to 0 only through the clear on exit.
- `zv`, `z`, `ch` hold while `zv & !zr`, which is backpressure. No bit is lost or duplicated.

## Timing
- Reset values: state=IDLE, `pri`=0, counter=0, `z`=0, `zv`=0, `ch`=0, `r0`=`r1`=0, `busy`=0, `stall_cnt`=0.
- Reset mid-burst drops the held output bit, and `zv` is 0 on the next cycle.
- IDLE→GRANT costs 1 cycle, and the first transfer is possible in the first GRANT cycle.
- Latency from accepted input bit to `zv` high is 1 cycle.
- Throughput is 1 bit/cycle within a burst when `zr` is held high.
- `r0`, `r1`, `busy` are combinational from state, `zv`, `zr`. No combinational path from `v*` or `d*` to `r*`.
- Arbitration gap: one IDLE cycle between consecutive bursts, including back-to-back bursts from the same channel.
- `BURST = 1`: each grant carries exactly one bit, and bits alternate 0,1,0,1 when both channels are continuously valid.

## Configuration
- `SERIAL_MERGE_STALL_CNT_EN` defined:
  - Adds an 8-bit counter `stall_cnt` that increments on every cycle with `zv & !zr`.
  - It saturates at 255 and clears only on reset.
- Not defined: no `stall_cnt` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset with `v0=v1=1`, then release: cycle 1 after release is IDLE→GRANT0. Then 4 bits of `d0` appear on `z` with `ch=0` on consecutive cycles, then 1 IDLE cycle, then the channel 1 burst with `ch=1`.
- Only `v1=1`, stream 1,0,1,1,0,0, `zr=1`, `BURST=4`: `z` = 1,0,1,1, one gap cycle, then 0,0. All bits carry `ch=1`.
- `zr=0` for 3 cycles mid-burst: `z`/`zv`/`ch` hold and `r0=0`. With the macro, `stall_cnt` increases by 3. After `zr=1`, the stream resumes with no lost or duplicated bit.
- `v0` drops after 2 of 4 bits while `v1=1`: GRANT0 exits to IDLE, `pri` becomes 1, and channel 1 is granted next.
- `rst_n=0` asserted during the third bit of a burst: next cycle `zv=0`, `r0=r1=0`, `busy=0`, `pri=0`.
- `BURST=1`, both channels valid, `d0=0`, `d1=1`, `zr=1` for 12 cycles: `z` sequence is 0,1,0,1,… with one IDLE gap cycle between bits.

Source files
------------

// File: rtl/serial_merge2.sv
// serial_merge2: burst round-robin merger of two 1-bit valid/ready sources into one
// registered output slot, with the channel select driving a gate-level mux2.
// Optional feature: define SERIAL_MERGE_STALL_CNT_EN to add the 8-bit stall_cnt_o
// counter (cycles with output valid but not ready, saturating at 255).

// Gate-level 2:1 multiplexer: y_o = sel_i ? b_i : a_i.
module mux2 (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);
  logic sel_n;
  logic t_a;
  logic t_b;

  not u_inv (sel_n, sel_i);
  and u_and_a (t_a, a_i, sel_n);
  and u_and_b (t_b, b_i, sel_i);
  or  u_or (y_o, t_a, t_b);
endmodule

module serial_merge2 #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       d0_i,
  input  logic       v0_i,
  output logic       r0_o,
  input  logic       d1_i,
  input  logic       v1_i,
  output logic       r1_o,
  output logic       z_o,
  output logic       zv_o,
  input  logic       zr_i,
  output logic       ch_o,
  output logic       busy_o
`ifdef SERIAL_MERGE_STALL_CNT_EN
  ,
  output logic [7:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e     state_q;
  logic       pri_q;
  logic [3:0] cnt_q;
  logic       z_q;
  logic       zv_q;
  logic       ch_q;

  logic       sel;
  logic       mux_y;
  logic       free;
  logic       xfer;
  logic       cur_v;
  logic [3:0] cnt_inc;
  logic       last;
  logic       grant_exit;

  assign sel = (state_q == StGrant1);

  mux2 u_mux (
    .a_i  (d0_i),
    .b_i  (d1_i),
    .sel_i(sel),
    .y_o  (mux_y)
  );

  // Handshake decode: readies depend only on state and the output slot, never on v*/d*.
  always_comb begin
    free       = !zv_q | zr_i;
    r0_o       = (state_q == StGrant0) & free;
    r1_o       = (state_q == StGrant1) & free;
    busy_o     = (state_q != StIdle);
    cur_v      = sel ? v1_i : v0_i;
    xfer       = (v0_i & r0_o) | (v1_i & r1_o);
    cnt_inc    = cnt_q + 4'd1;
    last       = (cnt_inc == 4'(BURST));
    // Leave on the burst-completing transfer or when the granted source goes idle.
    grant_exit = busy_o & free & (!cur_v | last);
  end

  // Arbiter FSM, burst counter, round-robin pointer and output slot.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pri_q   <= 1'b0;
      cnt_q   <= 4'd0;
      z_q     <= 1'b0;
      zv_q    <= 1'b0;
      ch_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (v0_i && v1_i) begin
            state_q <= pri_q ? StGrant1 : StGrant0;
          end else if (v0_i) begin
            state_q <= StGrant0;
          end else if (v1_i) begin
            state_q <= StGrant1;
          end
        end
        StGrant0, StGrant1: begin
          if (grant_exit) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            pri_q   <= ~sel;
          end else if (xfer) begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Slot loads on transfer, empties when consumed with nothing new, else holds.
      if (xfer) begin
        z_q  <= mux_y;
        ch_q <= sel;
        zv_q <= 1'b1;
      end else if (free) begin
        zv_q <= 1'b0;
      end
    end
  end

  assign z_o  = z_q;
  assign zv_o = zv_q;
  assign ch_o = ch_q;

`ifdef SERIAL_MERGE_STALL_CNT_EN
  logic [7:0] stall_cnt_q;

  // Saturating count of backpressured cycles; cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= 8'd0;
    end else if (zv_q && !zr_i && (stall_cnt_q != 8'hff)) begin
      stall_cnt_q <= stall_cnt_q + 8'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
